// File: rtl/seg7_mux_counter_pkg.sv
// Shared types, radix limits and glyph constants for the multiplexed
// 7-segment up/down counter, plus small per-digit arithmetic helpers.
package seg7_mux_counter_pkg;

  // One counter digit (hex or BCD nibble)
  typedef logic [3:0] digit_t;

  // Largest legal digit value in each radix
  localparam digit_t HEX_MAX = 4'hF;
  localparam digit_t BCD_MAX = 4'd9;

  // Segment glyphs, bit0=a .. bit6=g, active-high
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // Maximum digit value for the selected radix
  function automatic digit_t digit_max(input logic dec);
    return dec ? BCD_MAX : HEX_MAX;
  endfunction

  // A digit counts as "at maximum" if it equals the radix limit; in BCD a
  // stale hex value above 9 (after a radix switch) is treated the same way.
  function automatic logic digit_at_max(input digit_t d, input logic dec);
    return dec ? (d >= BCD_MAX) : (d == HEX_MAX);
  endfunction

  // One stage of the ripple chain. cin is the carry (up) or borrow (down)
  // arriving from the less significant digit; result is {cout, new_digit}.
  function automatic logic [4:0] step_digit(input digit_t d, input logic dec,
                                            input logic up, input logic cin);
    logic [4:0] r;
    r = {1'b0, d};
    if (cin) begin
      if (up) begin
        if (digit_at_max(d, dec)) r = {1'b1, 4'h0};
        else                      r = {1'b0, d + 4'd1};
      end else begin
        if (d == 4'd0)              r = {1'b1, digit_max(dec)};
        else if (dec && d > BCD_MAX) r = {1'b0, BCD_MAX - 4'd1};
        else                        r = {1'b0, d - 4'd1};
      end
    end
    return r;
  endfunction

  // Loaded digits above 9 saturate to 9 in BCD mode
  function automatic digit_t clamp_load(input digit_t d, input logic dec);
    return (dec && d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/seg7_mux_counter_seg7.sv
// Hex digit to 7-segment decoder (bit0=a .. bit6=g, active-high).
module seg7
  import seg7_mux_counter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  // Pure lookup of the glyph for one nibble
  always_comb begin
    segments = GLYPH_0;
    case (digit)
      4'h0: segments = GLYPH_0;
      4'h1: segments = GLYPH_1;
      4'h2: segments = GLYPH_2;
      4'h3: segments = GLYPH_3;
      4'h4: segments = GLYPH_4;
      4'h5: segments = GLYPH_5;
      4'h6: segments = GLYPH_6;
      4'h7: segments = GLYPH_7;
      4'h8: segments = GLYPH_8;
      4'h9: segments = GLYPH_9;
      4'hA: segments = GLYPH_A;
      4'hB: segments = GLYPH_B;
      4'hC: segments = GLYPH_C;
      4'hD: segments = GLYPH_D;
      4'hE: segments = GLYPH_E;
      4'hF: segments = GLYPH_F;
      default: segments = GLYPH_0;
    endcase
  end

endmodule

// File: rtl/seg7_mux_counter.sv
// Multi-digit hex/BCD up/down counter with a prescaled count tick and a
// time-multiplexed 7-segment display scan. A single seg7 decoder serves
// whichever digit the scan index currently selects.
module seg7_mux_counter
  import seg7_mux_counter_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int DIV      = 10000000,
  parameter int SCAN_DIV = 10000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   up,
  input  logic                   dec_mode,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_val,
  output logic [6:0]             seg,
  output logic [NDIGITS-1:0]     dig_sel,
  output logic                   dp,
  output logic                   wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);

  logic [PW-1:0] presc_reg;
  logic [SW-1:0] scan_reg;
  logic [IW-1:0] index_reg;
  logic          wrap_reg;
  digit_t        digits_reg [NDIGITS];

  digit_t        stepped    [NDIGITS];
  digit_t        load_digit [NDIGITS];
  logic          ripple;
  logic          tick;
  logic          scan_step;
  digit_t        sel_digit;

  // Count tick fires only while enabled, in the last prescaler cycle
  assign tick      = en && (presc_reg == PRESC_LAST);
  assign scan_step = (scan_reg == SCAN_LAST);

  // Per-digit load value, saturated to 9 when loading in BCD mode
  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_load
    assign load_digit[gi] = clamp_load(load_val[4*gi +: 4], dec_mode);
  end

  // Carry/borrow ripple through every digit in one cycle; the final
  // ripple out means the whole count wrapped
  always_comb begin
    ripple = 1'b1;
    for (int k = 0; k < NDIGITS; k++) begin
      {ripple, stepped[k]} = step_digit(digits_reg[k], dec_mode, up, ripple);
    end
  end

  // Prescaler: 0..DIV-1 while enabled, holds when paused, cleared by load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (load) begin
      presc_reg <= '0;
    end else if (en) begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
    end
  end

  // Digit registers: load beats a coincident tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NDIGITS; k++) digits_reg[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NDIGITS; k++) digits_reg[k] <= load_digit[k];
    end else if (tick) begin
      for (int k = 0; k < NDIGITS; k++) digits_reg[k] <= stepped[k];
    end
  end

  // Wrap flag is high for exactly the cycle the wrapped count is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= tick && !load && ripple;
    end
  end

  // Display scan runs continuously, independent of the count enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_reg  <= '0;
      index_reg <= '0;
    end else if (scan_step) begin
      scan_reg  <= '0;
      index_reg <= (index_reg == IDX_LAST) ? '0 : index_reg + 1'b1;
    end else begin
      scan_reg  <= scan_reg + 1'b1;
    end
  end

  assign sel_digit = digits_reg[index_reg];
  assign dig_sel   = NDIGITS'(1) << index_reg;
  assign dp        = (index_reg == '0) && !en;
  assign wrap      = wrap_reg;

  seg7 u_seg7 (
    .digit    (sel_digit),
    .segments (seg)
  );

endmodule

// File: doc/seg7_mux_counter.md
SEG7_MUX_COUNTER -- requirements
Module: seg7_mux_counter

Interface
REQ-001 SHALL have parameter NDIGITS, default 4: number of counter digits and display positions, legal range 1..8.
REQ-002 SHALL have parameter DIV, default 10000000: clk cycles per count tick, at least 2.
REQ-003 SHALL have parameter SCAN_DIV, default 10000: clk cycles per display scan step, at least 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  count enable; when 1, ticks update the count.
REQ-007 up  input  1  direction: 1 counts up, 0 counts down.
REQ-008 dec_mode  input  1  digit radix: 1 is BCD (0..9), 0 is hex (0..F).
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  4*NDIGITS  load value; digit k occupies bits [4k+3:4k].
REQ-011 seg  output  7  segment pattern of the selected digit (bit0=a .. bit6=g, active-high).
REQ-012 dig_sel  output  NDIGITS  one-hot, active-high digit select.
REQ-013 dp  output  1  decimal point of the selected digit.
REQ-014 wrap  output  1  one-cycle pulse on full-count wrap.

Function
REQ-015 Prescaler SHALL count 0..DIV-1 while en=1 and issue a tick in the cycle it equals DIV-1, then return to 0; tick period is exactly DIV cycles.
REQ-016 When en=0, the prescaler and the count SHALL hold.
REQ-017 On a tick with up=1, digit 0 SHALL increment.
- A digit at its maximum (9 in BCD, F in hex) becomes 0 and carries into the next digit.
- Carry ripples through all digits in the same cycle.
REQ-018 On a tick with up=0, digit 0 SHALL decrement.
- A digit at 0 becomes its maximum and borrows from the next digit.
REQ-019 In BCD mode, any digit above 9 (left over from a mode switch) SHALL be treated as maximum.
- Increment: it becomes 0 and carries.
- Decrement: it becomes 8.
REQ-020 wrap SHALL pulse high for the single cycle in which the count registers take a wrapped value.
- Up: all digits were at max and become all 0.
- Down: all digits were 0 and become all max.
REQ-021 load=1 SHALL copy load_val into the digits on the next edge and clear the prescaler; load has priority over a coincident tick.
REQ-022 In BCD mode, a loaded digit above 9 SHALL be stored as 9.
REQ-023 Changing up or dec_mode mid-count SHALL take effect at the next tick; it SHALL NOT alter the prescaler.
REQ-024 Scan counter SHALL run regardless of en and advance the display index 0,1,..,NDIGITS-1,0 every SCAN_DIV cycles.
REQ-025 dig_sel SHALL equal 1<<index.
REQ-026 seg SHALL equal the 7-segment decode of digit[index]; it is combinational from registered state with no added latency.
REQ-027 Decode SHALL map 0..F to standard hex glyphs, e.g. 0=7'h3F, 1=7'h06, 8=7'h7F, A=7'h77, F=7'h71.
REQ-028 dp SHALL be 1 only when index=0 and en=0 (paused indicator); otherwise dp SHALL be 0.

Reset
REQ-029 While rst_n=0, all registers SHALL be cleared asynchronously.
- Digits=0, prescaler=0, scan counter=0, index=0.
REQ-030 During and immediately after reset, outputs SHALL be seg=7'h3F, dig_sel=1, wrap=0, and dp=~en.
REQ-031 Reset asserted mid-tick or mid-load SHALL abandon the operation; the first tick after release occurs DIV cycles after counting resumes.

Structure
REQ-032 Shared package SHALL hold the 4-bit digit type, the hex/BCD maximum constants (4'hF, 4'd9) and the glyph table constants.
REQ-033 Segment decode SHALL be the existing sub-module seg7 (digit[3:0] -> segments[6:0]), instantiated once on the selected digit.
REQ-034 Counter chain, prescaler and scan logic SHALL live in this module.

Verification (NDIGITS=4, DIV=4, SCAN_DIV=2 unless stated)
REQ-035 Reset, en=1, up=1, hex -> count steps every 4 cycles, with 16 ticks giving 0x0010; seg=7'h3F during reset.
REQ-036 Load 0xFFFE, up=1, hex -> two ticks later count=0x0000 with a wrap pulse of exactly 1 cycle on that edge.
REQ-037 BCD mode, load 0x0000, up=0 -> one tick gives 0x9999 with wrap=1; load 0x12AB gives stored 0x1299.
REQ-038 Load asserted in the same cycle as a tick -> load_val stored, no increment; next tick arrives 4 cycles later.
REQ-039 Scan check: dig_sel sequence 1,2,4,8,1 changing every 2 cycles; seg matches seg7(digit[index]); dp=1 only at index 0 with en=0.
REQ-040 Assert rst_n=0 for 1 cycle mid-prescale at count 0x0042 -> all outputs return to reset values immediately, without waiting for a clock edge.
